// File: rtl/accum_dat_1_1_pkg.sv
// Shared constants and the frame-end rule for the frame accumulator.
// Width defaults live here so producer and consumer blocks agree on them.
package accum_dat_1_1_pkg;

  localparam int ACC_LEN_MAX     = 16;
  localparam int CNT_WIDTH       = 5;
  localparam int T_DAT_WIDTH_DEF = 16;
  localparam int I_DAT_WIDTH_DEF = 20;

  // A frame closes on the last counted slot or on an early last marker.
  function automatic logic frame_end(input logic [CNT_WIDTH-1:0] cnt,
                                     input logic                 last,
                                     input int                   acc_len);
    return last || (cnt == CNT_WIDTH'(acc_len - 1));
  endfunction

endpackage

// File: rtl/accum_dat_1_1.sv
// Sums signed samples into frames of up to ACC_LEN beats and emits one
// registered result per frame over a valid/ready handshake.
module accum_dat_1_1
  import accum_dat_1_1_pkg::*;
#(
  parameter int T_0_DAT_WIDTH = T_DAT_WIDTH_DEF,
  parameter int I_0_DAT_WIDTH = I_DAT_WIDTH_DEF,
  parameter int ACC_LEN       = ACC_LEN_MAX
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [T_0_DAT_WIDTH-1:0] t_0_dat,
  input  logic                     t_0_valid,
  input  logic                     t_0_last,
  output logic                     t_0_ready,
  output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
  output logic [CNT_WIDTH-1:0]     i_0_len,
  output logic                     i_0_valid,
  input  logic                     i_0_ready
);

  logic [I_0_DAT_WIDTH-1:0] sum_reg;
  logic [CNT_WIDTH-1:0]     cnt_reg;
  logic [I_0_DAT_WIDTH-1:0] sample_ext;
  logic [I_0_DAT_WIDTH-1:0] sum_next;
  logic                     accept;
  logic                     last_beat;

  // Input stalls only while a result is held and downstream is not taking it.
  assign t_0_ready  = ~i_0_valid | i_0_ready;
  assign accept     = t_0_valid & t_0_ready;
  assign sample_ext = {{(I_0_DAT_WIDTH - T_0_DAT_WIDTH){t_0_dat[T_0_DAT_WIDTH-1]}}, t_0_dat};
  assign sum_next   = sum_reg + sample_ext;
  assign last_beat  = frame_end(cnt_reg, t_0_last, ACC_LEN);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      sum_reg   <= '0;
      cnt_reg   <= '0;
      i_0_dat   <= '0;
      i_0_len   <= '0;
      i_0_valid <= 1'b0;
    end else begin
      if (i_0_valid && i_0_ready) begin
        i_0_valid <= 1'b0;
      end
      // A frame-end beat overrides the drain above, giving back-to-back results.
      if (accept) begin
        if (last_beat) begin
          i_0_dat   <= sum_next;
          i_0_len   <= cnt_reg + CNT_WIDTH'(1);
          i_0_valid <= 1'b1;
          sum_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          sum_reg <= sum_next;
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_dat_1_1.sv
// Self-checking bench: directed scenarios plus random traffic against a
// frame-level queue model of the accumulator.
module tb_accum_dat_1_1;

  localparam int TW = 16;
  localparam int IW = 20;
  localparam int AL = 16;

  typedef struct {
    int sum;
    int len;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [TW-1:0] t_0_dat = '0;
  logic          t_0_valid = 1'b0;
  logic          t_0_last = 1'b0;
  logic          t_0_ready;
  logic [IW-1:0] i_0_dat;
  logic [4:0]    i_0_len;
  logic          i_0_valid;
  logic          i_0_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  frame_t exp_q[$];
  int     m_sum = 0;
  int     m_cnt = 0;

  always #5 clk = ~clk;

  accum_dat_1_1 #(
    .T_0_DAT_WIDTH(TW),
    .I_0_DAT_WIDTH(IW),
    .ACC_LEN(AL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .t_0_dat(t_0_dat),
    .t_0_valid(t_0_valid),
    .t_0_last(t_0_last),
    .t_0_ready(t_0_ready),
    .i_0_dat(i_0_dat),
    .i_0_len(i_0_len),
    .i_0_valid(i_0_valid),
    .i_0_ready(i_0_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check outputs, then advance
  // the model by what the coming rising edge must do.
  task automatic cycle(input logic v, input logic [TW-1:0] d, input logic l, input logic r);
    logic [IW-1:0] exp_dat;
    logic          pend;
    logic          acc;
    @(negedge clk);
    t_0_valid = v;
    t_0_dat   = d;
    t_0_last  = l;
    i_0_ready = r;
    #1;
    pend = (exp_q.size() != 0);
    chk("out_valid", {31'd0, i_0_valid}, {31'd0, pend});
    if (pend) begin
      exp_dat = IW'(exp_q[0].sum);
      chk("out_dat", {12'd0, i_0_dat}, {12'd0, exp_dat});
      chk("out_len", {27'd0, i_0_len}, 32'(exp_q[0].len));
    end
    chk("in_ready", {31'd0, t_0_ready}, {31'd0, (!pend || r)});
    acc = v && (!pend || r);
    if (pend && r) void'(exp_q.pop_front());
    if (acc) begin
      m_sum += int'($signed(d));
      m_cnt++;
      if (m_cnt == AL || l) begin
        exp_q.push_back('{sum: m_sum, len: m_cnt});
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b1;
    t_0_valid = 1'b0;
    i_0_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, i_0_valid}, 32'd0);
    chk("rst_dat", {12'd0, i_0_dat}, 32'd0);
    chk("rst_len", {27'd0, i_0_len}, 32'd0);
    reset_n = 1'b0;
    exp_q.delete();
    m_sum = 0;
    m_cnt = 0;
  endtask

  // Directed result check, used right after an idle cycle with ready low.
  task automatic check_out(input string tag, input logic [IW-1:0] d, input logic [4:0] len);
    chk({tag, "_valid"}, {31'd0, i_0_valid}, 32'd1);
    chk({tag, "_dat"}, {12'd0, i_0_dat}, {12'd0, d});
    chk({tag, "_len"}, {27'd0, i_0_len}, {27'd0, len});
  endtask

  initial begin
    logic [IW-1:0] held_dat;
    logic [4:0]    held_len;

    do_reset();

    // 16 beats of max positive; result one cycle after the 16th beat.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h7FFF, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("pos16", 20'h7FFF0, 5'd16);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // 16 beats of max negative.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h8000, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("neg16", 20'h80000, 5'd16);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Early last on the third beat, then a fresh frame from zero.
    cycle(1'b1, 16'd1, 1'b0, 1'b1);
    cycle(1'b1, 16'd2, 1'b0, 1'b1);
    cycle(1'b1, 16'd3, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("early3", 20'd6, 5'd3);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'd5, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("fresh1", 20'd5, 5'd1);

    // Backpressure: result held for 5 cycles while input offers beats.
    held_dat = i_0_dat;
    held_len = i_0_len;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'd9, 1'b0, 1'b0);
      chk("bp_ready", {31'd0, t_0_ready}, 32'd0);
      chk("bp_dat", {12'd0, i_0_dat}, {12'd0, held_dat});
      chk("bp_len", {27'd0, i_0_len}, {27'd0, held_len});
    end
    cycle(1'b1, 16'd9, 1'b1, 1'b1);
    chk("bp_release", {31'd0, t_0_ready}, 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("bp_beat", 20'd9, 5'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Continuous input with ready high: back-to-back frames.
    for (int i = 0; i < 48; i++) cycle(1'b1, TW'($urandom), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-frame discards the partial sum.
    for (int i = 0; i < 7; i++) cycle(1'b1, 16'd100, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'd1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_out("post_rst", 20'd16, 5'd16);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Random traffic: sparse valid, occasional last, random backpressure.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), TW'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_dat_1_1.md
ACCUM_DAT_1_1 -- requirements
Module: accum_dat_1_1

Interface
REQ-001 SHALL have parameter T_0_DAT_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter I_0_DAT_WIDTH, default 20: signed accumulated output width, fed to round_sat_dat_1_1.
REQ-003 SHALL have parameter ACC_LEN, default 16: samples per frame, legal range 2..16.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset; synchronous, active-high (asserted = 1).
REQ-006 SHALL have port t_0_dat  input  T_0_DAT_WIDTH  signed input sample.
REQ-007 SHALL have port t_0_valid  input  1  input sample valid.
REQ-008 SHALL have port t_0_last  input  1  early frame end; qualified by t_0_valid.
REQ-009 SHALL have port t_0_ready  output  1  block can accept a sample.
REQ-010 SHALL have port i_0_dat  output  I_0_DAT_WIDTH  signed frame sum.
REQ-011 SHALL have port i_0_len  output  5  number of samples in the frame (1..ACC_LEN).
REQ-012 SHALL have port i_0_valid  output  1  i_0_dat/i_0_len valid.
REQ-013 SHALL have port i_0_ready  input  1  downstream accepts output.

Function
REQ-014 SHALL accept a beat when t_0_valid && t_0_ready in the same cycle; no other cycle changes accumulator state.
REQ-015 SHALL drive t_0_ready = ~i_0_valid | i_0_ready, combinationally; independent of t_0_valid/t_0_dat/t_0_last.
REQ-016 SHALL sign-extend t_0_dat to I_0_DAT_WIDTH and add it to the running sum; no saturation, no overflow possible (16 x 2^15 = 2^19).
REQ-017 SHALL hold a sample counter cnt (0..ACC_LEN-1) counting accepted beats in the current frame.
REQ-018 SHALL end a frame on an accepted beat where cnt == ACC_LEN-1 or t_0_last == 1, whichever first.
REQ-019 SHALL, on frame end, register i_0_dat = sum + sample, i_0_len = cnt+1, i_0_valid = 1, and clear sum and cnt to 0 in the same edge.
REQ-020 SHALL present the frame result on i_0_* exactly one cycle after the final beat is accepted (latency 1).
REQ-021 SHALL hold i_0_dat, i_0_len and i_0_valid stable while i_0_valid && ~i_0_ready.
REQ-022 SHALL clear i_0_valid on an edge where i_0_valid && i_0_ready and no frame ends.
REQ-023 SHALL, when i_0_valid && i_0_ready coincides with a frame-end beat, load the new result and keep i_0_valid = 1 (back-to-back, no bubble).
REQ-024 SHALL keep accumulating non-final beats while an output is pending and i_0_ready is low only if t_0_ready permits; with REQ-015 input stalls whenever output is pending and not drained.
REQ-025 SHALL treat t_0_last on a beat with cnt == ACC_LEN-1 as a single frame end (no empty frame emitted).
REQ-026 SHALL ignore t_0_last and t_0_dat when t_0_valid is low.

Reset
REQ-027 SHALL, while reset_n == 1 at a clock edge, set sum = 0, cnt = 0, i_0_valid = 0, i_0_dat = 0, i_0_len = 0.
REQ-028 SHALL discard any partial frame and any pending output on reset; t_0_ready = 1 in the first cycle after reset deasserts.

Structure
REQ-029 SHALL take ACC_LEN_MAX (16), the counter width (5) and the default data widths from the shared piston package; the frame-end condition is a package-level constant comparison only.
REQ-030 SHALL be a single module with no sub-modules; sum, cnt and output registers in one clocked process, t_0_ready as continuous logic.

Verification
REQ-031 SHALL cover: 16 beats of 0x7FFF, i_0_ready = 1 -> i_0_dat = 0x7FFF0, i_0_len = 16, i_0_valid one cycle after 16th beat.
REQ-032 SHALL cover: 16 beats of 0x8000 -> i_0_dat = 0x80000 (-524288), i_0_len = 16.
REQ-033 SHALL cover: beats 1, 2, 3 with t_0_last on 3rd -> i_0_dat = 6, i_0_len = 3; next frame starts from 0.
REQ-034 SHALL cover: output pending, i_0_ready = 0 for 5 cycles -> t_0_ready = 0, i_0_* stable; i_0_ready = 1 -> t_0_ready = 1 same cycle, no beat lost.
REQ-035 SHALL cover: continuous valid input, i_0_ready = 1 -> frames every 16 cycles, final beat of frame N+1 coinciding with drain of frame N, no bubble, correct sums.
REQ-036 SHALL cover: reset_n = 1 after 7 beats -> all outputs 0; next 16 beats of 1 -> i_0_dat = 16, i_0_len = 16.
